// File: rtl/parking_pkg.sv
// Shared definitions for the parking gate blocks: gate FSM states and
// default filter/timeout lengths used by counter and display logic too.
package parking_pkg;

  localparam int unsigned FILTER_CYCLES_DEF  = 500000;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 100000000;

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    IN_A       = 4'd1,
    IN_AB      = 4'd2,
    IN_B       = 4'd3,
    OUT_B      = 4'd4,
    OUT_AB     = 4'd5,
    OUT_A      = 4'd6,
    WAIT_CLEAR = 4'd7,
    FAULT      = 4'd8
  } gate_state_e;

endpackage

// File: rtl/gate_direction_fsm_if.sv
// Beam inputs and crossing outputs of one lane gate, bundled for the
// detector (slave) and whatever drives/observes it (master).
interface gate_direction_fsm_if;

  logic beam_a;
  logic beam_b;
  logic car_in;
  logic car_out;
  logic busy;
  logic fault;

  modport master (
    output beam_a, beam_b,
    input  car_in, car_out, busy, fault
  );

  modport slave (
    input  beam_a, beam_b,
    output car_in, car_out, busy, fault
  );

endinterface

// File: rtl/beam_filter.sv
// Two-flop synchroniser followed by a stable-count filter for one raw beam;
// the filtered output only follows a value held for FILTER_CYCLES cycles.
module beam_filter
  import parking_pkg::*;
#(
    parameter int unsigned FILTER_CYCLES = FILTER_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic filt
);

  localparam int unsigned CW = $clog2(FILTER_CYCLES + 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // For a single bit, "differs from filt" restarts exactly when the
  // synchronised value changes, so no separate previous-value flop is kept.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q == CW'(FILTER_CYCLES - 1)) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign filt = filt_q;

endmodule

// File: rtl/gate_direction_fsm.sv
// Lane gate direction detector: filters both beams, tracks the blocking
// sequence and emits one registered car_in/car_out pulse per crossing.
module gate_direction_fsm
  import parking_pkg::*;
#(
    parameter int unsigned FILTER_CYCLES  = FILTER_CYCLES_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    gate_direction_fsm_if.slave   gate
);

  localparam int unsigned DW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic          fa;
  logic          fb;
  logic [1:0]    ab;
  logic          timeout;
  gate_state_e   state_q, state_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic          pend_in_q, pend_in_d;
  logic          pend_out_q, pend_out_d;
  logic          car_in_q, car_out_q, busy_q, fault_q;

  beam_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filt_a (
    .clk   (clk),
    .reset (reset),
    .raw   (gate.beam_a),
    .filt  (fa)
  );

  beam_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filt_b (
    .clk   (clk),
    .reset (reset),
    .raw   (gate.beam_b),
    .filt  (fb)
  );

  assign ab = {fa, fb};

  always_comb begin
    timeout = (state_q != IDLE) && (state_q != FAULT) &&
              (dwell_q == DW'(TIMEOUT_CYCLES - 1));
    state_d = state_q;
    case (state_q)
      IDLE: case (ab)
        2'b10:   state_d = IN_A;
        2'b01:   state_d = OUT_B;
        2'b11:   state_d = WAIT_CLEAR;
        default: ;
      endcase
      IN_A: case (ab)
        2'b11:   state_d = IN_AB;
        2'b00:   state_d = IDLE;
        2'b01:   state_d = WAIT_CLEAR;
        default: ;
      endcase
      IN_AB: case (ab)
        2'b01:   state_d = IN_B;
        2'b10:   state_d = IN_A;
        2'b00:   state_d = WAIT_CLEAR;
        default: ;
      endcase
      IN_B: case (ab)
        2'b00:   state_d = IDLE;
        2'b11:   state_d = IN_AB;
        2'b10:   state_d = WAIT_CLEAR;
        default: ;
      endcase
      OUT_B: case (ab)
        2'b11:   state_d = OUT_AB;
        2'b00:   state_d = IDLE;
        2'b10:   state_d = WAIT_CLEAR;
        default: ;
      endcase
      OUT_AB: case (ab)
        2'b10:   state_d = OUT_A;
        2'b01:   state_d = OUT_B;
        2'b00:   state_d = WAIT_CLEAR;
        default: ;
      endcase
      OUT_A: case (ab)
        2'b00:   state_d = IDLE;
        2'b11:   state_d = OUT_AB;
        2'b01:   state_d = WAIT_CLEAR;
        default: ;
      endcase
      WAIT_CLEAR, FAULT: if (ab == 2'b00) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (timeout) state_d = FAULT;
  end

  // Completion is flagged on the transition into IDLE and released one
  // cycle later, so pulses trail the state register like busy and fault.
  always_comb begin
    dwell_d    = dwell_q;
    pend_in_d  = (state_q == IN_B)  && (state_d == IDLE);
    pend_out_d = (state_q == OUT_A) && (state_d == IDLE);
    if (state_d != state_q) begin
      dwell_d = '0;
    end else if ((state_q != IDLE) && (state_q != FAULT)) begin
      dwell_d = dwell_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      dwell_q    <= '0;
      pend_in_q  <= 1'b0;
      pend_out_q <= 1'b0;
      car_in_q   <= 1'b0;
      car_out_q  <= 1'b0;
      busy_q     <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      dwell_q    <= dwell_d;
      pend_in_q  <= pend_in_d;
      pend_out_q <= pend_out_d;
      car_in_q   <= pend_in_q;
      car_out_q  <= pend_out_q;
      busy_q     <= (state_q != IDLE);
      fault_q    <= (state_q == FAULT);
    end
  end

  assign gate.car_in  = car_in_q;
  assign gate.car_out = car_out_q;
  assign gate.busy    = busy_q;
  assign gate.fault   = fault_q;

endmodule
